// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Upstream stage of an NxN signed systolic matmul array. Buffers one A and one
// B matrix (one row of each per load beat), issues a single array-wide clear,
// then streams diagonally skewed operands into the west (A rows) and north
// (B columns) edges, and pulses done once every PE holds its final C element.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   load_valid  load beat offered
//   load_ready  beat accepted this cycle (combinational from state)
//   load_a_row  A row r, element k at [k*DW +: DW]
//   load_b_row  B row r, element j at [j*DW +: DW]
//   a_edge      west-edge operands, lane i feeds PE[i][0]
//   b_edge      north-edge operands, lane j feeds PE[0][j]
//   clear_out   one-cycle clear broadcast to every PE
//   busy        high in any state other than IDLE
//   done        one-cycle pulse, C results final
//
// state | meaning
// IDLE  | waiting for row 0 of a new job
// LOAD  | accepting rows 1..N-1
// CLEAR | one cycle, clear broadcast, edges zero
// FEED  | t = 0..3N-3, skewed operands then zero drain
// DONE  | one cycle, done pulse

module systolic_skew_feeder #(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [N*DW-1:0] load_a_row,
   input  logic [N*DW-1:0] load_b_row,
   output logic [N*DW-1:0] a_edge,
   output logic [N*DW-1:0] b_edge,
   output logic            clear_out,
   output logic            busy,
   output logic            done
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(3 * N) + 1;
   localparam logic [IW-1:0] BEAT_LAST = IW'(N - 1);
   localparam logic [TW-1:0] T_LAST    = TW'(3 * N - 3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_FEED,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   beat, beat_nxt;
   logic [TW-1:0]   t, t_nxt;
   logic            armed;
   logic            accept;
   logic [N*DW-1:0] a_nxt, b_nxt;

   logic [DW-1:0]   a_mem [N][N];
   logic [DW-1:0]   b_mem [N][N];

   // armed keeps load_ready low for the first cycle out of reset.
   assign load_ready = armed && ((state == S_IDLE) || (state == S_LOAD));
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      t_nxt     = t;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               beat_nxt  = IW'(1);
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (beat == BEAT_LAST) begin
                  beat_nxt  = '0;
                  state_nxt = S_CLEAR;
               end else begin
                  beat_nxt = beat + IW'(1);
               end
            end
         end
         S_CLEAR: begin
            t_nxt     = '0;
            state_nxt = S_FEED;
         end
         S_FEED: begin
            if (t == T_LAST) begin
               t_nxt     = '0;
               state_nxt = S_DONE;
            end else begin
               t_nxt = t + TW'(1);
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Edge values are computed from the next state and next t so that the
   // registered outputs show feed step t during the cycle in which t is held.
   // The subtraction runs at TW bits, wide enough that t-i never wraps.
   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      if (state_nxt == S_FEED) begin
         for (int i = 0; i < N; i++) begin
            if ((t_nxt >= TW'(i)) && ((t_nxt - TW'(i)) < TW'(N))) begin
               a_nxt[i*DW +: DW] = a_mem[i][IW'(t_nxt - TW'(i))];
               b_nxt[i*DW +: DW] = b_mem[IW'(t_nxt - TW'(i))][i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         beat      <= '0;
         t         <= '0;
         armed     <= 1'b0;
         a_edge    <= '0;
         b_edge    <= '0;
         clear_out <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         beat      <= beat_nxt;
         t         <= t_nxt;
         armed     <= 1'b1;
         a_edge    <= a_nxt;
         b_edge    <= b_nxt;
         clear_out <= (state_nxt == S_CLEAR);
         done      <= (state_nxt == S_DONE);
         busy      <= (state_nxt != S_IDLE);
      end
   end

   // beat is zero whenever the FSM sits in IDLE, so it addresses row 0 there.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < N; k++) begin
            a_mem[beat][k] <= load_a_row[k*DW +: DW];
            b_mem[beat][k] <= load_b_row[k*DW +: DW];
         end
      end
   end

endmodule
